// File: rtl/audio_dac_serializer_pkg.sv
// Shared definitions for the codec DAC transmit path: FSM states and default widths.
package audio_dac_serializer_pkg;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } dac_state_t;

    localparam int unsigned AUDIO_SAMPLE_WIDTH = 32;
    localparam int unsigned AUDIO_DATA_BITS    = 24;
    localparam int unsigned UNDERRUN_CNT_W     = 8;

endpackage

// File: rtl/audio_dac_serializer_lrck_edge_detect.sv
// Registers the codec frame clock and flags which channel a level change starts.
module audio_lrck_edge_detect #(
    parameter bit LEFT_LRCK = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic lrck,
    output logic left_edge,
    output logic right_edge
);

    logic lrck_q;
    logic lrck_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            lrck_q <= 1'b0;
        end else begin
            lrck_q <= lrck;
        end
    end

    always_comb begin
        lrck_edge  = (lrck != lrck_q);
        left_edge  = lrck_edge && (lrck == LEFT_LRCK);
        right_edge = lrck_edge && (lrck != LEFT_LRCK);
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Slave I2S / left-justified transmitter: one-pair holding buffer feeding a
// per-channel shift register framed by the codec-driven LRCK.
module audio_dac_serializer
    import audio_dac_serializer_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
    parameter int unsigned DATA_BITS    = AUDIO_DATA_BITS,
    parameter bit          I2S_DELAY    = 1'b1,
    parameter bit          LEFT_LRCK    = 1'b0
) (
    input  logic                      AUD_BCLK,
    input  logic                      reset,
    input  logic                      AUD_DACLRCK,
    input  logic [SAMPLE_WIDTH-1:0]   left_channel_audio_in,
    input  logic [SAMPLE_WIDTH-1:0]   right_channel_audio_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic                      AUD_DACDAT,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count,
    output logic                      in_sync
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_BITS);

    dac_state_t           state;
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_l;
    logic [DATA_BITS-1:0] hold_r;
    logic [DATA_BITS-1:0] last_l;
    logic [DATA_BITS-1:0] last_r;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bits_left;

    logic                 left_edge;
    logic                 right_edge;
    logic                 load_right;
    logic                 load;
    logic                 xfer;
    logic                 hold_full_next;
    logic [DATA_BITS-1:0] load_word;
    logic                 unused_upper;

    audio_lrck_edge_detect #(
        .LEFT_LRCK (LEFT_LRCK)
    ) u_edge (
        .clk        (AUD_BCLK),
        .reset      (reset),
        .lrck       (AUD_DACLRCK),
        .left_edge  (left_edge),
        .right_edge (right_edge)
    );

    // Only the low DATA_BITS of each sample are ever transmitted.
    assign unused_upper = ^{left_channel_audio_in, right_channel_audio_in};

    always_comb begin
        xfer       = sample_valid && sample_ready;
        load_right = right_edge && (state != ST_SYNC);
        load       = left_edge || load_right;
        load_word  = last_r;
        if (left_edge) begin
            load_word = hold_full ? hold_l : last_l;
        end
        hold_full_next = hold_full;
        if (left_edge && hold_full) begin
            hold_full_next = 1'b0;
        end else if (xfer) begin
            hold_full_next = 1'b1;
        end
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            state          <= ST_SYNC;
            hold_full      <= 1'b0;
            hold_l         <= '0;
            hold_r         <= '0;
            last_l         <= '0;
            last_r         <= '0;
            shreg          <= '0;
            bits_left      <= '0;
            sample_ready   <= 1'b0;
            AUD_DACDAT     <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
            in_sync        <= 1'b0;
        end else begin
            hold_full    <= hold_full_next;
            sample_ready <= !hold_full_next;
            underrun     <= 1'b0;

            if (xfer) begin
                hold_l <= left_channel_audio_in[DATA_BITS-1:0];
                hold_r <= right_channel_audio_in[DATA_BITS-1:0];
            end

            if (left_edge) begin
                if (hold_full) begin
                    last_l <= hold_l;
                    last_r <= hold_r;
                end else begin
                    underrun <= 1'b1;
                    if (underrun_count != '1) begin
                        underrun_count <= underrun_count + 1'b1;
                    end
                end
                in_sync <= 1'b1;
                state   <= ST_LEFT;
            end else if (load_right) begin
                state <= ST_RIGHT;
            end

            // Any channel edge restarts the shifter, dropping unsent bits of a short frame.
            if (load) begin
                if (I2S_DELAY) begin
                    AUD_DACDAT <= 1'b0;
                    shreg      <= load_word;
                    bits_left  <= FULL_CNT;
                end else begin
                    AUD_DACDAT <= load_word[DATA_BITS-1];
                    shreg      <= load_word << 1;
                    bits_left  <= FULL_CNT - 1'b1;
                end
            end else if (bits_left != '0) begin
                AUD_DACDAT <= shreg[DATA_BITS-1];
                shreg      <= shreg << 1;
                bits_left  <= bits_left - 1'b1;
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: I2S and left-justified instances driven in
// parallel and checked every BCLK against a frame-position reference model.
module tb_audio_dac_serializer;

    localparam int D = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrck;
    logic        valid;
    logic [31:0] lin;
    logic [31:0] rin;

    logic        dat_a, ready_a, und_a, sync_a;
    logic [7:0]  cnt_a;
    logic        dat_b, ready_b, und_b, sync_b;
    logic [7:0]  cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    audio_dac_serializer #(
        .SAMPLE_WIDTH (32),
        .DATA_BITS    (D),
        .I2S_DELAY    (1'b1),
        .LEFT_LRCK    (1'b0)
    ) dut_i2s (
        .AUD_BCLK               (clk),
        .reset                  (rst),
        .AUD_DACLRCK            (lrck),
        .left_channel_audio_in  (lin),
        .right_channel_audio_in (rin),
        .sample_valid           (valid),
        .sample_ready           (ready_a),
        .AUD_DACDAT             (dat_a),
        .underrun               (und_a),
        .underrun_count         (cnt_a),
        .in_sync                (sync_a)
    );

    audio_dac_serializer #(
        .SAMPLE_WIDTH (32),
        .DATA_BITS    (D),
        .I2S_DELAY    (1'b0),
        .LEFT_LRCK    (1'b0)
    ) dut_lj (
        .AUD_BCLK               (clk),
        .reset                  (rst),
        .AUD_DACLRCK            (lrck),
        .left_channel_audio_in  (lin),
        .right_channel_audio_in (rin),
        .sample_valid           (valid),
        .sample_ready           (ready_b),
        .AUD_DACDAT             (dat_b),
        .underrun               (und_b),
        .underrun_count         (cnt_b),
        .in_sync                (sync_b)
    );

    initial forever #5 clk = ~clk;

    // Reference model: frame position since the last channel edge selects the bit.
    logic        m_lrck_q, m_hold_full, m_ready, m_synced, m_active, m_und, m_xfer;
    logic [31:0] m_hold_l, m_hold_r, m_last_l, m_last_r, m_word;
    int          m_pos, m_cnt, n_acc;
    logic        bp_mode = 1'b0;
    logic        rnd_mode = 1'b0;
    logic        cap_a [64];
    logic        cap_b [64];
    int          cap_n;

    function automatic logic exp_bit(input logic [31:0] w, input int pos, input int delay);
        int idx;
        idx = pos - delay;
        if (idx < 0 || idx >= D) return 1'b0;
        return w[D-1-idx];
    endfunction

    function automatic logic [31:0] word_a(input int start, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], cap_a[start+i]};
        return w;
    endfunction

    function automatic logic [31:0] word_b(input int start, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], cap_b[start+i]};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_lrck_q = 1'b0; m_hold_full = 1'b0; m_ready = 1'b0; m_synced = 1'b0;
            m_active = 1'b0; m_und = 1'b0; m_xfer = 1'b0; m_cnt = 0; m_pos = 0;
            m_hold_l = '0; m_hold_r = '0; m_last_l = '0; m_last_r = '0; m_word = '0;
        end else begin
            m_xfer = valid && m_ready;
            m_und  = 1'b0;
            if (lrck != m_lrck_q && lrck == 1'b0) begin
                if (m_hold_full) begin
                    m_last_l = m_hold_l & 32'h00FF_FFFF;
                    m_last_r = m_hold_r & 32'h00FF_FFFF;
                    m_hold_full = 1'b0;
                end else begin
                    m_und = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                m_synced = 1'b1; m_active = 1'b1; m_word = m_last_l; m_pos = 0;
            end else if (lrck != m_lrck_q && m_synced) begin
                m_word = m_last_r; m_pos = 0;
            end else if (m_pos < 1000) begin
                m_pos++;
            end
            if (m_xfer) begin
                m_hold_l = lin; m_hold_r = rin; m_hold_full = 1'b1; n_acc++;
            end
            m_lrck_q = lrck;
            m_ready  = !m_hold_full;
        end
    endtask

    task automatic step();
        logic ea, eb;
        @(posedge clk);
        model_update();
        ea = m_active ? exp_bit(m_word, m_pos, 1) : 1'b0;
        eb = m_active ? exp_bit(m_word, m_pos, 0) : 1'b0;
        #1;
        chk("dat_i2s",   32'(dat_a),   32'(ea));
        chk("dat_lj",    32'(dat_b),   32'(eb));
        chk("ready_i2s", 32'(ready_a), 32'(m_ready));
        chk("ready_lj",  32'(ready_b), 32'(m_ready));
        chk("und_i2s",   32'(und_a),   32'(m_und));
        chk("und_lj",    32'(und_b),   32'(m_und));
        chk("cnt_i2s",   32'(cnt_a),   32'(m_cnt));
        chk("cnt_lj",    32'(cnt_b),   32'(m_cnt));
        chk("sync_i2s",  32'(sync_a),  32'(m_synced));
        chk("sync_lj",   32'(sync_b),  32'(m_synced));
        if (cap_n < 64) begin
            cap_a[cap_n] = dat_a;
            cap_b[cap_n] = dat_b;
            cap_n++;
        end
        if (bp_mode && m_xfer) begin
            lin = lin + 1;
            rin = rin + 1;
        end
        if (rnd_mode) begin
            valid = 1'($urandom_range(0, 1));
            if (m_xfer) begin
                lin = $urandom;
                rin = $urandom;
            end
        end
    endtask

    task automatic frame(input logic level, input int len);
        lrck  = level;
        cap_n = 0;
        repeat (len) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dat"},   32'(dat_a | dat_b),     32'd0);
        chk({tag, "_und"},   32'(und_a | und_b),     32'd0);
        chk({tag, "_cnt"},   32'(cnt_a | cnt_b),     32'd0);
        chk({tag, "_sync"},  32'(sync_a | sync_b),   32'd0);
        chk({tag, "_ready"}, 32'(ready_a | ready_b), 32'd0);
    endtask

    logic [31:0] sl, sr;

    initial begin
        n_acc = 0;
        cap_n = 0;
        rst = 1'b1; lrck = 1'b1; valid = 1'b0; lin = '0; rin = '0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(ready_a), 32'd1);

        // Basic I2S / left-justified frame with a preloaded pair.
        lin = 32'h00A5_0F3C; rin = 32'h00FF_0001; valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (2) step();
        chk("presync_in_sync", 32'(sync_a), 32'd0);
        frame(1'b0, 32);
        chk("basic_left_i2s", word_a(1, 24), 32'h00A5_0F3C);
        chk("basic_lead_i2s", 32'(cap_a[0]), 32'd0);
        chk("basic_tail_i2s", word_a(25, 7), 32'd0);
        chk("basic_left_lj",  word_b(0, 24), 32'h00A5_0F3C);
        frame(1'b1, 32);
        chk("basic_right_i2s", word_a(1, 24), 32'h00FF_0001);
        chk("basic_right_lj",  word_b(0, 24), 32'h00FF_0001);
        chk("basic_no_underrun", 32'(cnt_a), 32'd0);

        // Underrun: no new pair for three frames, last pair repeats.
        for (int f = 0; f < 3; f++) begin
            frame(1'b0, 32);
            chk("underrun_repeat_l", word_a(1, 24), 32'h00A5_0F3C);
            frame(1'b1, 32);
            chk("underrun_repeat_r", word_b(0, 24), 32'h00FF_0001);
        end
        chk("underrun_count3", 32'(cnt_a), 32'd3);

        // Backpressure: valid held high, each accepted pair advances by one.
        bp_mode = 1'b1; lin = 32'd1; rin = 32'd101; valid = 1'b1;
        frame(1'b1, 8);
        for (int k = 1; k <= 4; k++) begin
            frame(1'b0, 32);
            chk("bp_left_seq",  word_a(1, 24), 32'(k));
            frame(1'b1, 32);
            chk("bp_right_seq", word_b(0, 24), 32'(100 + k));
        end
        chk("bp_accepted", 32'(n_acc), 32'd6);
        chk("bp_no_new_underrun", 32'(cnt_b), 32'd3);
        bp_mode = 1'b0; valid = 1'b0;

        // Sync from the right level, then 10-BCLK short frames.
        rst = 1'b1; lrck = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        sl = $urandom; sr = $urandom;
        lin = sl; rin = sr; valid = 1'b1;
        step();
        valid = 1'b0;
        frame(1'b1, 10);
        chk("short_presync", 32'(sync_b), 32'd0);
        for (int f = 0; f < 3; f++) begin
            frame(1'b0, 10);
            chk("short_left_i2s", word_a(1, 9),  32'(sl[23:15]));
            chk("short_left_lj",  word_b(0, 10), 32'(sl[23:14]));
            frame(1'b1, 10);
            chk("short_right_i2s", word_a(1, 9), 32'(sr[23:15]));
        end

        // Reset at bit 12 of a left channel.
        frame(1'b1, 32);
        lrck = 1'b0; cap_n = 0;
        repeat (13) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        chk_reset_outputs("midreset");
        repeat (16) step();
        frame(1'b1, 32);
        chk("midreset_quiet", 32'(sync_a), 32'd0);
        frame(1'b0, 32);
        chk("midreset_underrun", 32'(cnt_a), 32'd1);
        chk("midreset_zero_word", word_a(1, 24), 32'd0);

        // Random frame lengths, handshake and data.
        rnd_mode = 1'b1;
        for (int f = 0; f < 30; f++) begin
            frame(1'(f % 2 == 0), $urandom_range(3, 40));
        end
        rnd_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
